// File: rtl/dcnn_pkg.sv
// ---------------------------------------------------------------------------
// dcnn_pkg
// Shared constants and types for the CNN datapath blocks.
//   DATA_WIDTH  width of one signed Q-format word
//   KSIZE       side of a convolution window
//   BLOCK_SIZE  words per window (KSIZE*KSIZE)
//   IDX_W       width of a word index inside a window
//   word_t      one signed word
//   block_t     one complete window of words
//   state_t     stream FSM states of dma_block_streamer
// ---------------------------------------------------------------------------
package dcnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int KSIZE      = 5;
    localparam int BLOCK_SIZE = KSIZE * KSIZE;
    localparam int IDX_W      = 5;

    typedef logic signed [DATA_WIDTH-1:0] word_t;
    typedef word_t block_t [BLOCK_SIZE];

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

endpackage

// File: rtl/block_bank.sv
// ---------------------------------------------------------------------------
// block_bank
// One window-sized register bank: the whole window is written in a single
// cycle, words are read back one at a time by index, and a full flag tells
// the owner whether the bank currently holds an unconsumed window.
// Ports:
//   clk      clock, all logic on posedge
//   rst_n    asynchronous active-low reset (clears the full flag only)
//   wr_en    capture wr_data into the bank and mark it full
//   wr_data  flattened window, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   clr      window consumed, mark the bank empty
//   rd_idx   index of the word presented on rd_data
//   rd_data  stored word at rd_idx
//   full     bank holds a window that has not been fully streamed
// ---------------------------------------------------------------------------
module block_bank
    import dcnn_pkg::*;
#(
    parameter int DATA_WIDTH = dcnn_pkg::DATA_WIDTH,
    parameter int BLOCK_SIZE = dcnn_pkg::BLOCK_SIZE,
    parameter int IDX_W      = dcnn_pkg::IDX_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] wr_data,
    input  logic                             clr,
    input  logic [IDX_W-1:0]                 rd_idx,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             full
);

    logic [DATA_WIDTH-1:0] mem [BLOCK_SIZE];

    // Word storage carries no reset: stale contents are harmless because
    // nothing is read from a bank whose full flag is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mem[i] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The owner never writes a full bank nor clears an empty one, so the
    // priority between wr_en and clr never matters in practice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dma_block_streamer.sv
// ---------------------------------------------------------------------------
// dma_block_streamer
// Captures parallel KSIZE x KSIZE windows from the DMA into two ping-pong
// banks and streams them word by word to the convolution PE over a
// valid/ready handshake. One bank can fill while the other drains.
//
// Build option: STREAMER_TRANSPOSE_EN
//   defined   - words leave in column-major order; out_index still reports
//               the row-major position of each word inside its window
//   undefined - words leave in row-major order (out_index = sequence number)
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   blk_valid  DMA window present on blk_data
//   blk_ready  a bank is free; window accepted on blk_valid & blk_ready
//   blk_data   flattened window, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out_data holds a valid word
//   out_ready  PE accepts the word on out_valid & out_ready
//   out_data   signed word, forwarded bit-exact
//   out_index  row-major position of out_data inside its window
//   out_last   final word of a window
// ---------------------------------------------------------------------------
module dma_block_streamer
    import dcnn_pkg::*;
#(
    parameter  int DATA_WIDTH = dcnn_pkg::DATA_WIDTH,
    parameter  int KSIZE      = dcnn_pkg::KSIZE,
    parameter  int IDX_W      = dcnn_pkg::IDX_W,
    localparam int BLOCK_SIZE = KSIZE * KSIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             blk_valid,
    output logic                             blk_ready,
    input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] blk_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [DATA_WIDTH-1:0]     out_data,
    output logic [IDX_W-1:0]                 out_index,
    output logic                             out_last
);

    localparam logic [IDX_W-1:0] LAST_SEQ = IDX_W'(BLOCK_SIZE - 1);

    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        seq;
    logic [IDX_W-1:0]        next_seq;
    logic                    rd_bank;
    logic                    next_rd_bank;
    logic                    wr_bank;
    logic [1:0]              full;
    logic                    load;
    logic                    blk_done;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_data0;
    logic [DATA_WIDTH-1:0]   rd_data1;

    // Maps the emission sequence number to the source word position.
    function automatic logic [IDX_W-1:0] src_of(input logic [IDX_W-1:0] s);
`ifdef STREAMER_TRANSPOSE_EN
        int v;
        v = int'(s);
        return IDX_W'((v % KSIZE) * KSIZE + v / KSIZE);
`else
        return s;
`endif
    endfunction

    // Ready looks only at registered flags, never at out_ready, so the DMA
    // side has no combinational path from the PE side.
    assign blk_ready = ~full[wr_bank];
    assign load      = blk_valid & blk_ready;
    assign rd_idx    = src_of(seq);

    block_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .IDX_W      (IDX_W)
    ) bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (load & ~wr_bank),
        .wr_data (blk_data),
        .clr     (blk_done & ~rd_bank),
        .rd_idx  (rd_idx),
        .rd_data (rd_data0),
        .full    (full[0])
    );

    block_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .IDX_W      (IDX_W)
    ) bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (load & wr_bank),
        .wr_data (blk_data),
        .clr     (blk_done & rd_bank),
        .rd_idx  (rd_idx),
        .rd_data (rd_data1),
        .full    (full[1])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
        end else if (load) begin
            wr_bank <= ~wr_bank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            seq     <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= next_state;
            seq     <= next_seq;
            rd_bank <= next_rd_bank;
        end
    end

    // On the last handshake of a window we jump straight into the other
    // bank when it is already full, so consecutive windows leave gap-free.
    always_comb begin
        next_state   = state;
        next_seq     = seq;
        next_rd_bank = rd_bank;
        blk_done     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_index    = '0;
        out_data     = '0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    next_state = STREAM;
                    next_seq   = '0;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_index = rd_idx;
                out_data  = rd_bank ? rd_data1 : rd_data0;
                out_last  = (seq == LAST_SEQ);
                if (out_ready) begin
                    if (seq == LAST_SEQ) begin
                        blk_done     = 1'b1;
                        next_seq     = '0;
                        next_rd_bank = ~rd_bank;
                        next_state   = full[~rd_bank] ? STREAM : IDLE;
                    end else begin
                        next_seq = seq + 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_block_streamer.sv
// ---------------------------------------------------------------------------
// tb_dma_block_streamer
// Scoreboard bench for dma_block_streamer. Every window the DMA side gets
// accepted is expanded by a reference model into its expected word stream
// and queued; an independent monitor compares each presented word against
// the head of that queue. Directed sections cover latency, back-to-back
// windows, back-pressure, negative data and asynchronous reset; a random
// section follows. Honours STREAMER_TRANSPOSE_EN for the emission order.
// ---------------------------------------------------------------------------
module tb_dma_block_streamer;
    import dcnn_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int BS = BLOCK_SIZE;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 blk_valid = 1'b0;
    logic                 blk_ready;
    logic [DW*BS-1:0]     blk_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic [IDX_W-1:0]     out_index;
    logic                 out_last;

    typedef struct {
        logic [DW-1:0]    data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    dma_block_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Reference model: walk the window in emission order (rows outer for
    // row-major, columns outer for column-major) and list the words.
    task automatic pushBlock(input logic [DW*BS-1:0] blk);
        exp_t e;
        int   n;
        int   idx;
        n = 0;
        for (int a = 0; a < KSIZE; a++) begin
            for (int b = 0; b < KSIZE; b++) begin
`ifdef STREAMER_TRANSPOSE_EN
                idx = b * KSIZE + a;
`else
                idx = a * KSIZE + b;
`endif
                e.data = blk[idx*DW +: DW];
                e.idx  = IDX_W'(idx);
                e.last = (n == BS - 1);
                exp_q.push_back(e);
                n++;
            end
        end
    endtask

    // Acceptance watcher: a window handed over at the next edge enters the scoreboard.
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            pushBlock(blk_data);
        end
    end

    // Output monitor: a presented word must match the scoreboard head, and
    // only a handshake retires it, so stalled words are checked every cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_word actual=idx%0d/0x%0h required=none", out_index, out_data);
            end else begin
                e = exp_q[0];
                checkOutput("out_data", 32'($unsigned(out_data)), 32'(e.data));
                checkOutput("out_index", 32'(out_index), 32'(e.idx));
                checkOutput("out_last", 32'(out_last), 32'(e.last));
                if (out_ready) begin
                    e = exp_q.pop_front();
                end
            end
        end
    end

    function automatic logic [DW*BS-1:0] randBlock();
        logic [DW*BS-1:0] b;
        for (int i = 0; i < BS; i++) begin
            b[i*DW +: DW] = DW'($urandom);
        end
        return b;
    endfunction

    // Offers one window and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [DW*BS-1:0] blk);
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        blk_valid = 1'b1;
        blk_data  = blk;
        @(negedge clk);
        while (!blk_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!blk_ready) begin
            failNow("accept_timeout");
        end
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
    endtask

    task automatic waitDrain(input int bound);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < bound) begin
            guard++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            failNow("drain_timeout");
            exp_q.delete();
        end
    endtask

    initial begin
        logic [DW*BS-1:0] blk;
        logic [DW*BS-1:0] blk_b;
        int               vcnt;
        int               guard;
        logic             acc;

        // Reset state, checked without any clock edge involvement.
        #2 rst_n = 1'b0;
        #4;
        checkOutput("rst_blk_ready", 32'(blk_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_out_index", 32'(out_index), 32'd0);
        checkOutput("rst_out_data", 32'($unsigned(out_data)), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single window with fill latency check.
        $display("[TB] single window");
        for (int i = 0; i < BS; i++) begin
            blk[i*DW +: DW] = DW'(16'h0400 + i);
        end
        blk[0*DW +: DW] = 16'h0800;
        blk[1*DW +: DW] = 16'h0400;
        blk[2*DW +: DW] = 16'h1000;
        blk[3*DW +: DW] = 16'h0400;
        out_ready = 1'b1;
        applyStimulus(blk);
        @(negedge clk);
        checkOutput("latency_edge_n", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_edge_n1", 32'(out_valid), 32'd1);
        waitDrain(100);
        @(posedge clk);
        @(negedge clk);
        checkOutput("single_idle_after", 32'(out_valid), 32'd0);

        // Back-to-back windows, a refused third, gap-free streaming.
        $display("[TB] back-to-back");
        @(posedge clk);
        #1;
        blk_valid = 1'b1;
        blk_data  = randBlock();
        @(negedge clk);
        checkOutput("b2b_ready_a", 32'(blk_ready), 32'd1);
        @(posedge clk);
        #1;
        blk_data = randBlock();
        @(negedge clk);
        checkOutput("b2b_ready_b", 32'(blk_ready), 32'd1);
        @(posedge clk);
        #1;
        blk_data = randBlock();
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            vcnt += int'(out_valid);
            if (i == 0) begin
                checkOutput("third_refused", 32'(blk_ready), 32'd0);
            end
            if (i == 24) begin
                checkOutput("ready_before_free", 32'(blk_ready), 32'd0);
            end
            if (i == 25) begin
                checkOutput("ready_after_free", 32'(blk_ready), 32'd1);
            end
            if (i == 0) begin
                @(posedge clk);
                #1;
                blk_valid = 1'b0;
            end
        end
        checkOutput("b2b_no_gap", 32'(vcnt), 32'd50);
        @(negedge clk);
        checkOutput("b2b_idle_after", 32'(out_valid), 32'd0);
        waitDrain(100);

        // Back-pressure: hold three cycles while word 7 is presented.
        $display("[TB] back-pressure");
        applyStimulus(randBlock());
        guard = 0;
        while (!(out_valid && out_index == IDX_W'(7)) && guard < 100) begin
            guard++;
            @(posedge clk);
            #1;
        end
        if (!(out_valid && out_index == IDX_W'(7))) begin
            failNow("stall_reach_7");
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_index", 32'(out_index), 32'd7);
            checkOutput("stall_last", 32'(out_last), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("resume_index", 32'(out_index), 32'd7);
        @(negedge clk);
        checkOutput("resume_next", 32'(out_index), 32'd8);
        waitDrain(100);

        // Negative words must survive bit-exact.
        $display("[TB] negative data");
        blk = randBlock();
        blk[8*DW +: DW]  = 16'hF000;
        blk[13*DW +: DW] = 16'hD800;
        applyStimulus(blk);
        guard = 0;
        while (!(out_valid && out_index == IDX_W'(8)) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        checkOutput("neg_word8", 32'($unsigned(out_data)), 32'h0000F000);
        guard = 0;
        while (!(out_valid && out_index == IDX_W'(13)) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        checkOutput("neg_word13", 32'($unsigned(out_data)), 32'h0000D800);
        waitDrain(100);

        // Ramp window: word i = i, exposes the emission order.
        $display("[TB] ramp window");
        for (int i = 0; i < BS; i++) begin
            blk[i*DW +: DW] = DW'(i);
        end
        applyStimulus(blk);
        waitDrain(100);

        // Asynchronous reset mid-window with a second window buffered.
        $display("[TB] async reset");
        applyStimulus(randBlock());
        applyStimulus(randBlock());
        guard = 0;
        while (!(out_valid && out_index == IDX_W'(12)) && guard < 100) begin
            guard++;
            @(posedge clk);
            #1;
        end
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_out_last", 32'(out_last), 32'd0);
        checkOutput("arst_out_index", 32'(out_index), 32'd0);
        checkOutput("arst_out_data", 32'($unsigned(out_data)), 32'd0);
        checkOutput("arst_blk_ready", 32'(blk_ready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("no_stale_valid", 32'(out_valid), 32'd0);
        end

        // Random traffic on both sides; a refused window is held unchanged.
        $display("[TB] random traffic");
        blk_valid = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            acc = blk_valid && blk_ready;
            @(posedge clk);
            #1;
            if (!blk_valid || acc) begin
                blk_valid = ($urandom_range(0, 2) == 0);
                if (blk_valid) begin
                    blk_data = randBlock();
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        guard = 0;
        while (blk_valid && guard < 200) begin
            guard++;
            @(negedge clk);
            acc = blk_valid && blk_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                blk_valid = 1'b0;
            end
        end
        if (blk_valid) begin
            failNow("random_final_accept");
            blk_valid = 1'b0;
        end
        waitDrain(200);
        @(posedge clk);
        @(negedge clk);
        checkOutput("random_idle_after", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_block_streamer.md
# dma_block_streamer

Downstream of the DMA read port in the CNN datapath. Captures each parallel 25-word block (one 5×5 window of signed Q-format 16-bit values) into one of two ping-pong banks. Streams the words one per cycle to the convolution PE over a valid/ready handshake. Double buffering lets the DMA deliver the next window while the current one drains, hiding DMA read latency.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one signed word
- KSIZE, 5, window side; BLOCK_SIZE = KSIZE*KSIZE (25)
- IDX_W, 5, width of word index (≥ clog2(BLOCK_SIZE))

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- blk_valid  in  1  DMA block present on blk_data
- blk_ready  out  1  a bank is free; block accepted when blk_valid & blk_ready
- blk_data  in  DATA_WIDTH*BLOCK_SIZE  flattened block, word i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  PE accepts word when out_valid & out_ready
- out_data  out  DATA_WIDTH  signed word, passed through unmodified
- out_index  out  IDX_W  source index (0..24) of out_data within its block
- out_last  out  1  high with the final word of a block

## Operation
- Two banks, each BLOCK_SIZE words plus a full flag. Pointers: wr_bank (next bank to fill) and rd_bank (bank being streamed), both reset to 0.
- Load: on blk_valid & blk_ready, all 25 words are written into bank[wr_bank] in one cycle. That bank's full flag is set and wr_bank toggles.
- blk_ready = ~full[wr_bank], a combinational function of registered state only. It must not depend on out_ready.
- Stream FSM:
  - IDLE → STREAM when full[rd_bank]; seq counter = 0.
  - In STREAM: out_valid = 1. out_data = bank[rd_bank][src(seq)], where src is defined under Configuration. out_index = src(seq). out_last = (seq == BLOCK_SIZE-1).
  - Each handshake increments seq.
  - On the handshake with out_last: clear full[rd_bank], toggle rd_bank, reset seq to 0. Stay in STREAM if the other bank is full, otherwise go to IDLE. There are no bubbles between back-to-back blocks.
- Stall: when out_valid & ~out_ready, out_data, out_index and out_last hold stable.
- Simultaneous load into a bank and release of the other bank is legal; both take effect.
- The bank freed by the last handshake is loadable from the next cycle (blk_ready rises one cycle after that handshake).
- blk_valid while blk_ready = 0: the block is ignored, and the DMA must hold it.
- No arithmetic is performed. Words are stored and forwarded bit-exact, with sign preserved.

## Timing
- Reset values:
  - blk_ready = 1
  - out_valid = 0, out_last = 0, out_index = 0, out_data = 0
  - both full flags = 0, FSM = IDLE
- Latency: block accepted at edge N gives out_valid = 1 with word 0 after edge N+1 (one-cycle fill latency).
- Throughput: with out_ready held at 1, one word per cycle, 25 cycles per block, sustained indefinitely when the DMA supplies a block every ≤25 cycles.
- Reset mid-block: all flags clear immediately (async). Partial blocks are discarded, and streaming restarts from IDLE after rst_n deasserts.
- Capacity: at most two blocks buffered. A third block is back-pressured.

## Configuration
- STREAMER_TRANSPOSE_EN defined: src(seq) = (seq % KSIZE)*KSIZE + seq/KSIZE, i.e. column-major emission. out_index reports the row-major source index.
- Not defined: src(seq) = seq, i.e. row-major emission and out_index = seq.
- Handshake, latency and out_last position are identical in both builds.

## Structure
- Shared package dcnn_pkg holds:
  - DATA_WIDTH, KSIZE, BLOCK_SIZE, IDX_W constants
  - typedef word_t (signed [DATA_WIDTH-1:0])
  - typedef block_t (word_t [BLOCK_SIZE])
  - stream FSM state enum {IDLE, STREAM}
- One sub-module, block_bank: a single BLOCK_SIZE-word register bank with parallel write, indexed read and full flag. It is instantiated twice.

## Test plan
- Single block: load words 0x0800, 0x0400, 0x1000, 0x0400, … (word i = 0x0400+i elsewhere), out_ready = 1. Required: out_valid rises 1 cycle after acceptance, 25 words emitted in order, out_last only on index 24, then out_valid = 0.
- Back-to-back: two blocks offered on consecutive cycles. Required: both accepted (blk_ready = 1, 1), a third is refused (blk_ready = 0), and 50 words stream with no gap between index 24 and the next index 0.
- Backpressure: drop out_ready for 3 cycles at seq 7. Required: out_data, out_index = 7 and out_last = 0 held stable, and streaming resumes at 7 with no loss or duplication.
- Negative data: block with word 8 = 0xF000 and word 13 = 0xD800. Required: emitted bit-exact at indices 8 and 13.
- Async reset at seq 12 of block 1 with block 2 buffered. Required: outputs go to reset values without waiting for clk, blk_ready = 1, and no stale words after reset.
- STREAMER_TRANSPOSE_EN build: block word i = i. Required: out_data sequence 0, 5, 10, 15, 20, 1, 6, …, 24, with out_index equal to out_data.
